pipelined_datapath: RTL and testbench
=====================================

# pipelined_datapath

- Parametrised, two-stage successor to the 16×16 register-file/ALU datapath.
- Stage 1 reads two operands, selects the immediate, and accepts one instruction per cycle through a valid/ready handshake.
- Stage 2 executes, writes back, and updates flags.
- Sits between the instruction controller and the memory/bus interface; replaces the flat sixteen-register output bundle with a parametrised debug read port.

## Interface
Parameters:
- DATA_W, 16, operand/register width (≥8)
- NUM_REGS, 16, register count (power of two, ≥2); SEL_W = $clog2(NUM_REGS)
- FLAG_W, 5, fixed; flags = {N, C, F, L, Z} (bit4..bit0)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  datapath accepts this cycle
- opcode  in  8  ALU operation (package constants)
- a_sel, b_sel  in  SEL_W  source registers
- dst_sel  in  SEL_W  destination register
- wr_en  in  1  write result to dst_sel
- use_imm  in  1  B operand = immediate
- immediate  in  DATA_W  immediate operand
- bus_select  in  1  writeback source = bus_data instead of ALU
- bus_data  in  DATA_W  external load data, sampled at accept
- flags_en  in  1  update flags with ALU flags
- out_valid  out  1  stage-2 instruction completing this cycle
- result  out  DATA_W  stage-2 writeback value
- flags  out  5  architectural flag register
- dbg_sel  in  SEL_W  debug read address
- dbg_data  out  DATA_W  combinational register content at dbg_sel

## Operation
- Accept: in_valid && in_ready. At the accept edge, stage 1 latches into the EX register:
  - operand A
  - operand B (register or immediate)
  - bus_data
  - opcode, dst_sel, wr_en, bus_select, flags_en
  - ex_valid = 1
- Stage 2 (EX valid) computes the ALU on the latched operands. result = bus_select ? latched bus_data : alu_out.
- At the next edge:
  - Register dst_sel ← result if wr_en.
  - flags ← alu_flags if flags_en. Flags still update when bus_select = 1.
- Opcodes (8-bit): AND 0x01, OR 0x02, XOR 0x03, ADD 0x05, ADDC 0x07, SUB 0x09, CMP 0x0B, MOV 0x0D, LSH 0x84. Unknown opcodes give result 0 and flags unchanged.
- Arithmetic rules:
  - Results are truncated to DATA_W.
  - C = carry-out (ADD/ADDC) or borrow (SUB/CMP).
  - F = signed overflow.
  - L = unsigned A<B (CMP).
  - Z = result==0.
  - N = signed A<B (CMP).
  - ADDC adds flags.C.
  - CMP never requires wr_en; the controller must drive wr_en=0 for CMP.
  - LSH: B[DATA_W-1]=0 → A<<1, else A>>1 logical.
  - MOV passes B.
- Operand hazard: a source register equal to the EX dst with EX wr_en && ex_valid.
- Flag hazard: ADDC issued while EX flags_en && ex_valid.
- Hazard handling is set by Configuration.
- A write and a debug read of the same register in the same cycle returns the old value.

## Timing
- Reset values: all registers 0, flags 0, ex_valid 0, out_valid 0, result 0, in_ready 1.
- Latency: accept at edge N → out_valid/result during cycle N+1 → register/flags written at edge N+1.
- Throughput: 1 instruction/cycle when hazard-free.
- out_valid = ex_valid. Stage 2 never stalls; it has no downstream backpressure.
- in_ready is combinational from stage-1 selects and EX state only, never from in_valid.
- When in_valid = 0, a bubble enters EX and ex_valid drops.
- Reset mid-operation: the EX instruction is discarded with no writeback, and flags clear immediately (asynchronous).

## Configuration
- DATAPATH_FWD_EN defined:
  - EX result forwards to stage-1 A/B reads on register match.
  - EX alu_flags.C forwards to ADDC carry-in.
  - in_ready is tied 1.
- DATAPATH_FWD_EN undefined:
  - No bypass.
  - in_ready = 0 for one cycle on an operand or flag hazard.
  - The held instruction is accepted the following cycle, after writeback.

## Structure
- Package pipelined_datapath_pkg holds:
  - opcode localparams
  - flag bit-index constants (FLAG_N=4, FLAG_C=3, FLAG_F=2, FLAG_L=1, FLAG_Z=0)
  - the EX-register struct typedef
- One sub-module, dp_regbank:
  - parametrised NUM_REGS × DATA_W array
  - one write port, three asynchronous read ports (A, B, debug)
  - active-low async reset
- The ALU stays inline in the top.

## Test plan
- Reset asserted mid-stream with EX valid → all registers 0, flags 0, out_valid 0, no write observed on dbg_data.
- Immediate 0x0005 into r1 via MOV with use_imm, then ADD r2=r1+imm 0x0003 back-to-back:
  - With FWD_EN: r2=0x0008, in_ready stays 1.
  - Without FWD_EN: one in_ready-low cycle, then r2=0x0008.
- ADD 0xFFFF+0x0001 with flags_en → result 0x0000, Z=1, C=1. A following ADDC 0x0000+0x0000 → result 0x0001.
- CMP 0x0002 vs 0x8000 → L=1, N=0, no register write.
- Load with bus_select=1, bus_data=0xBEEF into r7 → dbg_sel=7 reads 0xBEEF one cycle after out_valid.
- DATA_W=32, NUM_REGS=8 instance: SUB 0 − 1 → 0xFFFFFFFF, C(borrow)=1, N per signed rule; LSH 0x80000000 right → 0x40000000.

Source files
------------

// File: rtl/pipelined_datapath_pkg.sv
// pipelined_datapath_pkg: opcodes, flag bit positions and the EX-stage control record
// shared by the two-stage datapath.
`default_nettype none

package pipelined_datapath_pkg;

    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_MOV  = 8'h0D;
    localparam logic [7:0] OP_LSH  = 8'h84;

    localparam int FLAG_W = 5;
    localparam int FLAG_N = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_Z = 0;

    // Width-independent part of the EX register; operands and dst live beside it.
    typedef struct packed {
        logic [7:0] opcode;
        logic       wr_en;
        logic       bus_select;
        logic       flags_en;
        logic       carry_in;
    } ex_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/dp_regbank.sv
// dp_regbank: NUM_REGS x DATA_W register array, one write port and three
// asynchronous read ports (A, B, debug).
`default_nettype none

module dp_regbank
    import pipelined_datapath_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] wr_sel,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic [$clog2(NUM_REGS)-1:0] a_sel,
    output logic [DATA_W-1:0]           a_data,
    input  logic [$clog2(NUM_REGS)-1:0] b_sel,
    output logic [DATA_W-1:0]           b_data,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
    output logic [DATA_W-1:0]           dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_sel] <= wr_data;
        end
    end

    assign a_data   = regs[a_sel];
    assign b_data   = regs[b_sel];
    assign dbg_data = regs[dbg_sel];

endmodule

`default_nettype wire

// File: rtl/pipelined_datapath.sv
// pipelined_datapath: two-stage register-file/ALU datapath (read+select, execute+writeback).
// Define DATAPATH_FWD_EN for EX->stage-1 bypassing instead of one-cycle hazard stalls.
`default_nettype none

module pipelined_datapath
    import pipelined_datapath_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  opcode,
    input  logic [$clog2(NUM_REGS)-1:0] a_sel,
    input  logic [$clog2(NUM_REGS)-1:0] b_sel,
    input  logic [$clog2(NUM_REGS)-1:0] dst_sel,
    input  logic                        wr_en,
    input  logic                        use_imm,
    input  logic [DATA_W-1:0]           immediate,
    input  logic                        bus_select,
    input  logic [DATA_W-1:0]           bus_data,
    input  logic                        flags_en,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           result,
    output logic [4:0]                  flags,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
    output logic [DATA_W-1:0]           dbg_data
);

    localparam int SEL_W = $clog2(NUM_REGS);
    localparam int MSB   = DATA_W - 1;

    logic              ex_valid;
    ex_ctrl_t          ex_ctrl;
    logic [DATA_W-1:0] ex_a, ex_b, ex_bus;
    logic [SEL_W-1:0]  ex_dst;

    logic [DATA_W-1:0] rf_a, rf_b, src_a, src_b, op_b;
    logic [DATA_W-1:0] alu_out, wb_data;
    logic [DATA_W:0]   sum;
    logic [FLAG_W-1:0] alu_flags, flags_next;
    logic              alu_known, carry_in, accept, ex_writes, hz_a, hz_b;

    dp_regbank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regbank (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (ex_writes),
        .wr_sel   (ex_dst),
        .wr_data  (wb_data),
        .a_sel    (a_sel),
        .a_data   (rf_a),
        .b_sel    (b_sel),
        .b_data   (rf_b),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    assign ex_writes = ex_valid && ex_ctrl.wr_en;
    assign hz_a      = ex_writes && (a_sel == ex_dst);
    assign hz_b      = ex_writes && !use_imm && (b_sel == ex_dst);

`ifdef DATAPATH_FWD_EN
    assign src_a    = hz_a ? wb_data : rf_a;
    assign src_b    = hz_b ? wb_data : rf_b;
    assign carry_in = flags_next[FLAG_C];
    assign in_ready = 1'b1;
`else
    logic hz_f;
    assign hz_f     = (opcode == OP_ADDC) && ex_valid && ex_ctrl.flags_en;
    assign src_a    = rf_a;
    assign src_b    = rf_b;
    assign carry_in = flags[FLAG_C];
    assign in_ready = !(hz_a || hz_b || hz_f);
`endif

    assign op_b   = use_imm ? immediate : src_b;
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_bus   <= '0;
            ex_dst   <= '0;
        end else begin
            ex_valid <= accept;
            if (accept) begin
                ex_a               <= src_a;
                ex_b               <= op_b;
                ex_bus             <= bus_data;
                ex_dst             <= dst_sel;
                ex_ctrl.opcode     <= opcode;
                ex_ctrl.wr_en      <= wr_en;
                ex_ctrl.bus_select <= bus_select;
                ex_ctrl.flags_en   <= flags_en;
                ex_ctrl.carry_in   <= carry_in;
            end
        end
    end

    // Borrow is the extended-width sign bit of A-B, so C is shared with ADD's carry slot.
    always_comb begin
        sum       = '0;
        alu_out   = '0;
        alu_flags = '0;
        alu_known = 1'b1;
        case (ex_ctrl.opcode)
            OP_AND: alu_out = ex_a & ex_b;
            OP_OR:  alu_out = ex_a | ex_b;
            OP_XOR: alu_out = ex_a ^ ex_b;
            OP_ADD, OP_ADDC: begin
                sum = {1'b0, ex_a} + {1'b0, ex_b}
                    + {{DATA_W{1'b0}}, (ex_ctrl.opcode == OP_ADDC) && ex_ctrl.carry_in};
                alu_out           = sum[MSB:0];
                alu_flags[FLAG_C] = sum[DATA_W];
                alu_flags[FLAG_F] = (ex_a[MSB] == ex_b[MSB]) && (alu_out[MSB] != ex_a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                sum               = {1'b0, ex_a} - {1'b0, ex_b};
                alu_out           = sum[MSB:0];
                alu_flags[FLAG_C] = sum[DATA_W];
                alu_flags[FLAG_F] = (ex_a[MSB] != ex_b[MSB]) && (alu_out[MSB] != ex_a[MSB]);
                alu_flags[FLAG_L] = ex_a < ex_b;
                alu_flags[FLAG_N] = $signed(ex_a) < $signed(ex_b);
            end
            OP_MOV: alu_out = ex_b;
            OP_LSH: alu_out = ex_b[MSB] ? (ex_a >> 1) : (ex_a << 1);
            default: alu_known = 1'b0;
        endcase
        alu_flags[FLAG_Z] = (alu_out == '0);
    end

    assign wb_data    = ex_ctrl.bus_select ? ex_bus : alu_out;
    assign result     = ex_valid ? wb_data : '0;
    assign out_valid  = ex_valid;
    assign flags_next = (ex_valid && ex_ctrl.flags_en && alu_known) ? alu_flags : flags;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else begin
            flags <= flags_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_datapath.sv
// tb_pipelined_datapath: directed spec scenarios plus randomized instruction stream
// checked against an instruction-level reference model (16-bit) and a 32x8 instance.
`default_nettype none

module tb_pipelined_datapath;
    import pipelined_datapath_pkg::*;

`ifdef DATAPATH_FWD_EN
    localparam int EXP_STALL = 0;
`else
    localparam int EXP_STALL = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        in_valid, in_ready, wr_en, use_imm, bus_select, flags_en, out_valid;
    logic [7:0]  opcode;
    logic [3:0]  a_sel, b_sel, dst_sel, dbg_sel;
    logic [15:0] immediate, bus_data, result, dbg_data;
    logic [4:0]  flags;

    pipelined_datapath #(.DATA_W(16), .NUM_REGS(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a_sel(a_sel), .b_sel(b_sel), .dst_sel(dst_sel),
        .wr_en(wr_en), .use_imm(use_imm), .immediate(immediate),
        .bus_select(bus_select), .bus_data(bus_data), .flags_en(flags_en),
        .out_valid(out_valid), .result(result), .flags(flags),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    logic        wide_in_valid, wide_in_ready, wide_wr_en, wide_use_imm, wide_bus_select;
    logic        wide_flags_en, wide_out_valid;
    logic [7:0]  wide_opcode;
    logic [2:0]  wide_a_sel, wide_b_sel, wide_dst_sel, wide_dbg_sel;
    logic [31:0] wide_immediate, wide_bus_data, wide_result, wide_dbg_data;
    logic [4:0]  wide_flags;

    pipelined_datapath #(.DATA_W(32), .NUM_REGS(8)) dut_wide (
        .clk(clk), .reset(reset), .in_valid(wide_in_valid), .in_ready(wide_in_ready),
        .opcode(wide_opcode), .a_sel(wide_a_sel), .b_sel(wide_b_sel), .dst_sel(wide_dst_sel),
        .wr_en(wide_wr_en), .use_imm(wide_use_imm), .immediate(wide_immediate),
        .bus_select(wide_bus_select), .bus_data(wide_bus_data), .flags_en(wide_flags_en),
        .out_valid(wide_out_valid), .result(wide_result), .flags(wide_flags),
        .dbg_sel(wide_dbg_sel), .dbg_data(wide_dbg_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction-level reference model: architectural state updated in program order.
    typedef struct {
        logic [15:0] res;
        logic [4:0]  flg;
    } exp_t;

    logic [15:0] m_regs [16];
    logic [4:0]  m_flags;
    exp_t        exp_q [$];
    logic        flg_pend;
    logic [4:0]  flg_pend_val;

    function automatic void ref_exec(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                                     input logic cin, output logic [15:0] res,
                                     output logic known, output logic [4:0] fl);
        int ua, ub, sa, sb, s, ss, c;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        fl = '0;
        known = 1'b1;
        res = '0;
        s = 0;
        case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_ADD, OP_ADDC: begin
                c = (op == OP_ADDC) ? int'(cin) : 0;
                s = ua + ub + c;
                ss = sa + sb + c;
                res = s[15:0];
                fl[FLAG_C] = (s > 65535);
                fl[FLAG_F] = (ss > 32767) || (ss < -32768);
            end
            OP_SUB, OP_CMP: begin
                s = ua - ub;
                ss = sa - sb;
                res = s[15:0];
                fl[FLAG_C] = (s < 0);
                fl[FLAG_F] = (ss > 32767) || (ss < -32768);
                fl[FLAG_L] = (ua < ub);
                fl[FLAG_N] = (sa < sb);
            end
            OP_MOV: res = b;
            OP_LSH: begin
                s = b[15] ? (ua / 2) : ((ua * 2) % 65536);
                res = s[15:0];
            end
            default: known = 1'b0;
        endcase
        fl[FLAG_Z] = (res == 16'h0000);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_flags = '0;
        exp_q.delete();
        flg_pend = 1'b0;
    endtask

    // One cycle: at the falling edge, check the completing instruction and last cycle's flags.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (flg_pend) begin
            check("flags", flags, flg_pend_val);
            flg_pend = 1'b0;
        end
        check("out_valid", out_valid, exp_q.size() > 0);
        if (out_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("result", result, e.res);
            flg_pend = 1'b1;
            flg_pend_val = e.flg;
        end
    endtask

    task automatic idle();
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        idle();
    endtask

    task automatic issue(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic we, input logic ui,
                         input logic [15:0] imm, input logic bs, input logic [15:0] bd,
                         input logic fe, output int stalls);
        logic        acc, known;
        logic [15:0] av, bv, res, wb;
        logic [4:0]  fl;
        exp_t        e;
        stalls = 0;
        acc = 1'b0;
        for (int k = 0; k < 6 && !acc; k++) begin
            tick();
            opcode = op; a_sel = a; b_sel = b; dst_sel = d; wr_en = we; use_imm = ui;
            immediate = imm; bus_select = bs; bus_data = bd; flags_en = fe; in_valid = 1'b1;
            #1;
            if (in_ready) acc = 1'b1;
            else stalls++;
        end
        if (!acc) begin
            check("accept_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
        end else begin
            av = m_regs[a];
            bv = ui ? imm : m_regs[b];
            ref_exec(op, av, bv, m_flags[FLAG_C], res, known, fl);
            wb = bs ? bd : res;
            if (fe && known) m_flags = fl;
            if (we) m_regs[d] = wb;
            e.res = wb;
            e.flg = m_flags;
            exp_q.push_back(e);
        end
    endtask

    task automatic issue_wide(input logic [7:0] op, input logic [2:0] a, input logic [2:0] d,
                              input logic [31:0] imm, input logic fe, output logic [31:0] res);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        wide_opcode = op; wide_a_sel = a; wide_b_sel = '0; wide_dst_sel = d; wide_wr_en = 1'b1;
        wide_use_imm = 1'b1; wide_immediate = imm; wide_bus_select = 1'b0; wide_flags_en = fe;
        wide_in_valid = 1'b1;
        for (int k = 0; k < 4 && !acc; k++) begin
            #1;
            if (wide_in_ready) acc = 1'b1;
            else @(negedge clk);
        end
        if (!acc) check("wide_accept_timeout", wide_in_ready, 1'b1);
        @(negedge clk);
        wide_in_valid = 1'b0;
        check("wide_out_valid", wide_out_valid, 1'b1);
        res = wide_result;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout expected completion)");
        $fatal(1);
    end

    initial begin
        int          st;
        logic [31:0] wres;
        logic [7:0]  ops [13];
        logic [7:0]  op;
        logic [3:0]  ra, rb, rd;

        ops = '{OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDC, OP_SUB, OP_CMP, OP_MOV, OP_LSH,
                8'h00, 8'h04, 8'h0F, 8'hFF};
        reset = 1'b0;
        in_valid = 0; opcode = 0; a_sel = 0; b_sel = 0; dst_sel = 0; wr_en = 0; use_imm = 0;
        immediate = 0; bus_select = 0; bus_data = 0; flags_en = 0; dbg_sel = 0;
        wide_in_valid = 0; wide_opcode = 0; wide_a_sel = 0; wide_b_sel = 0; wide_dst_sel = 0;
        wide_wr_en = 0; wide_use_imm = 0; wide_immediate = 0; wide_bus_select = 0;
        wide_bus_data = 0; wide_flags_en = 0; wide_dbg_sel = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_result", result, 16'h0000);
        check("reset_flags", flags, 5'b00000);
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            #1;
            check("reset_reg", dbg_data, 16'h0000);
        end

        // MOV r1,#5 then ADD r2=r1+#3 back-to-back
        issue(OP_MOV, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 16'h0005, 1'b0, 16'h0, 1'b0, st);
        issue(OP_ADD, 4'd1, 4'd0, 4'd2, 1'b1, 1'b1, 16'h0003, 1'b0, 16'h0, 1'b0, st);
        check("raw_stall_cycles", st, EXP_STALL);
        drain();
        dbg_sel = 4'd2; #1;
        check("r2_after_add", dbg_data, 16'h0008);

        // 0xFFFF+1 sets Z and C; an immediately following ADDC consumes that carry
        issue(OP_MOV, 4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0, 1'b0, st);
        issue(OP_ADD, 4'd3, 4'd0, 4'd4, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0, 1'b1, st);
        issue(OP_ADDC, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, st);
        check("flag_stall_cycles", st, EXP_STALL);
        drain();
        check("add_flags_zc", flags, 5'b01001);
        dbg_sel = 4'd4; #1;
        check("r4_add_wrap", dbg_data, 16'h0000);
        dbg_sel = 4'd5; #1;
        check("r5_addc", dbg_data, 16'h0001);

        // CMP 2 vs 0x8000, no write to r9
        issue(OP_MOV, 4'd0, 4'd0, 4'd6, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0, 1'b0, st);
        issue(OP_CMP, 4'd6, 4'd0, 4'd9, 1'b0, 1'b1, 16'h8000, 1'b0, 16'h0, 1'b1, st);
        drain();
        check("cmp_L", flags[FLAG_L], 1'b1);
        check("cmp_N", flags[FLAG_N], 1'b0);
        check("cmp_flags", flags, 5'b01110);
        dbg_sel = 4'd9; #1;
        check("cmp_no_write", dbg_data, 16'h0000);

        // Bus load into r7: old value during the writeback cycle, new one after
        issue(OP_MOV, 4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0, st);
        idle();
        dbg_sel = 4'd7; #1;
        check("dbg_during_write", dbg_data, 16'h0000);
        idle();
        #1;
        check("dbg_after_load", dbg_data, 16'hBEEF);

        // Asynchronous reset with an instruction in EX
        issue(OP_MOV, 4'd0, 4'd0, 4'd8, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0, 1'b0, st);
        @(negedge clk);
        in_valid = 1'b0;
        check("ex_valid_before_reset", out_valid, 1'b1);
        reset = 1'b0;
        #1;
        check("async_reset_out_valid", out_valid, 1'b0);
        check("async_reset_flags", flags, 5'b00000);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            #1;
            check("midreset_reg", dbg_data, 16'h0000);
        end
        model_reset();
        reset = 1'b1;

        // 32-bit, 8-register instance
        issue_wide(OP_SUB, 3'd0, 3'd1, 32'h1, 1'b1, wres);
        check("wide_sub_result", wres, 32'hFFFF_FFFF);
        @(negedge clk);
        check("wide_sub_borrow", wide_flags[FLAG_C], 1'b1);
        check("wide_sub_flags", wide_flags, 5'b11010);
        issue_wide(OP_MOV, 3'd0, 3'd2, 32'h8000_0000, 1'b0, wres);
        issue_wide(OP_LSH, 3'd2, 3'd3, 32'h8000_0000, 1'b0, wres);
        check("wide_lsh_right", wres, 32'h4000_0000);
        @(negedge clk);
        wide_dbg_sel = 3'd3; #1;
        check("wide_r3", wide_dbg_data, 32'h4000_0000);

        // Randomized stream, registers concentrated on r0-r3 to provoke hazards
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle();
            op = ops[$urandom_range(0, 12)];
            ra = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            rb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            rd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            issue(op, ra, rb, rd, (op != OP_CMP) && ($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 1)), 16'($urandom()),
                  ($urandom_range(0, 7) == 0), 16'($urandom()), 1'($urandom_range(0, 1)), st);
        end
        drain();
        check("random_final_flags", flags, m_flags);
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            #1;
            check("random_final_reg", dbg_data, m_regs[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
